// File: rtl/horizontal_timing.sv
// Horizontal video timing: pixel-rate divider, column counter, end-of-line strobe
// and a region FSM that produces registered hsync / h_visible.
//
// state     | meaning
// S_VISIBLE | active video, h_counter 0 .. H_VISIBLE-1
// S_FRONT   | front porch
// S_SYNC    | sync pulse, hsync driven to HSYNC_POL
// S_BACK    | back porch, ends on wrap to column 0
module horizontal_timing #(
    parameter int   CLK_DIV   = 4,
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter logic HSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        pix_tick,
    output logic [15:0] h_counter,
    output logic        en_v_counter,
    output logic        hsync,
    output logic        h_visible
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0]      H_LAST      = 16'(H_TOTAL - 1);
    localparam logic [15:0]      FRONT_START = 16'(H_VISIBLE);
    localparam logic [15:0]      SYNC_START  = 16'(H_VISIBLE + H_FRONT);
    localparam logic [15:0]      BACK_START  = 16'(H_VISIBLE + H_FRONT + H_SYNC);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("horizontal_timing: CLK_DIV must be at least 1");
    end
    if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1) begin : g_bad_region
        $error("horizontal_timing: every region length must be non-zero");
    end
    if (H_TOTAL > 65535) begin : g_bad_total
        $error("horizontal_timing: H_TOTAL exceeds 16-bit column range");
    end

    typedef enum logic [1:0] {S_VISIBLE, S_FRONT, S_SYNC, S_BACK} state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] div;
    logic [15:0]      h_next;
    logic             div_last;

    assign div_last = (div == DIV_LAST);

    // Strobes are combinational so the vertical counter advances on the wrap edge.
    assign pix_tick     = run && div_last && !rst;
    assign en_v_counter = pix_tick && (h_counter == H_LAST);

    assign h_next = (h_counter == H_LAST) ? 16'd0 : h_counter + 16'd1;

    // Next region is decided from the column being loaded, keeping state and counter aligned.
    always_comb begin
        state_next = state;
        unique case (state)
            S_VISIBLE: if (h_next == FRONT_START) state_next = S_FRONT;
            S_FRONT:   if (h_next == SYNC_START)  state_next = S_SYNC;
            S_SYNC:    if (h_next == BACK_START)  state_next = S_BACK;
            S_BACK:    if (h_next == 16'd0)       state_next = S_VISIBLE;
            default:   state_next = S_VISIBLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            h_counter <= 16'd0;
            state     <= S_VISIBLE;
            h_visible <= 1'b1;
            hsync     <= ~HSYNC_POL;
        end else if (run) begin
            div <= div_last ? '0 : div + DIV_W'(1);
            if (div_last) begin
                h_counter <= h_next;
                state     <= state_next;
                h_visible <= (state_next == S_VISIBLE);
                hsync     <= (state_next == S_SYNC) ? HSYNC_POL : ~HSYNC_POL;
            end
        end
    end

endmodule

// File: tb/tb_horizontal_timing.sv
// Directed bench for horizontal_timing: default timing, CLK_DIV=1, and a tiny
// inverted-sync configuration driven from a vector table.
module tb_horizontal_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default configuration
    logic        rst_d, run_d, pix_d, en_d, hs_d, vis_d;
    logic [15:0] h_d;
    // CLK_DIV = 1
    logic        rst_f, run_f, pix_f, en_f, hs_f, vis_f;
    logic [15:0] h_f;
    // small line, positive sync, CLK_DIV = 2
    logic        rst_s, run_s, pix_s, en_s, hs_s, vis_s;
    logic [15:0] h_s;

    horizontal_timing u_def (
        .clk(clk), .rst(rst_d), .run(run_d), .pix_tick(pix_d), .h_counter(h_d),
        .en_v_counter(en_d), .hsync(hs_d), .h_visible(vis_d)
    );

    horizontal_timing #(.CLK_DIV(1)) u_fast (
        .clk(clk), .rst(rst_f), .run(run_f), .pix_tick(pix_f), .h_counter(h_f),
        .en_v_counter(en_f), .hsync(hs_f), .h_visible(vis_f)
    );

    horizontal_timing #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1), .HSYNC_POL(1'b1)
    ) u_small (
        .clk(clk), .rst(rst_s), .run(run_s), .pix_tick(pix_s), .h_counter(h_s),
        .en_v_counter(en_s), .hsync(hs_s), .h_visible(vis_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          clks;
        logic        run;
        logic [15:0] h;
        logic        tick;
        logic        hs;
        logic        vis;
        logic        en;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int clks, input logic run, input logic [15:0] h,
                                input logic tick, input logic hs, input logic vis,
                                input logic en);
        vec_t v;
        v.clks = clks; v.run = run; v.h = h; v.tick = tick; v.hs = hs; v.vis = vis; v.en = en;
        vecs.push_back(v);
    endfunction

    initial begin
        int first_en, second_en, bad, hs_ticks, vis_ticks, hs_min, hs_max, h_max, n;
        logic [15:0] h_at_en;

        // Small line (8/2/3/1, CLK_DIV=2, hsync active high): sampled on tick cycles.
        //  clks run   h  tick hs vis en
        add(0, 1'b1, 16'd0,  1'b0, 1'b0, 1'b1, 1'b0);
        add(1, 1'b1, 16'd0,  1'b1, 1'b0, 1'b1, 1'b0);
        add(2, 1'b1, 16'd1,  1'b1, 1'b0, 1'b1, 1'b0);
        add(2, 1'b1, 16'd2,  1'b1, 1'b0, 1'b1, 1'b0);
        add(2, 1'b1, 16'd3,  1'b1, 1'b0, 1'b1, 1'b0);
        add(2, 1'b1, 16'd4,  1'b1, 1'b0, 1'b1, 1'b0);
        add(2, 1'b1, 16'd5,  1'b1, 1'b0, 1'b1, 1'b0);
        add(2, 1'b1, 16'd6,  1'b1, 1'b0, 1'b1, 1'b0);
        add(2, 1'b1, 16'd7,  1'b1, 1'b0, 1'b1, 1'b0);
        add(2, 1'b1, 16'd8,  1'b1, 1'b0, 1'b0, 1'b0);
        add(2, 1'b1, 16'd9,  1'b1, 1'b0, 1'b0, 1'b0);
        add(2, 1'b1, 16'd10, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2, 1'b1, 16'd11, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2, 1'b1, 16'd12, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2, 1'b1, 16'd13, 1'b1, 1'b0, 1'b0, 1'b1);
        add(0, 1'b0, 16'd13, 1'b0, 1'b0, 1'b0, 1'b0);
        add(3, 1'b0, 16'd13, 1'b0, 1'b0, 1'b0, 1'b0);
        add(0, 1'b1, 16'd13, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1, 1'b1, 16'd0,  1'b0, 1'b0, 1'b1, 1'b0);
        add(1, 1'b1, 16'd0,  1'b1, 1'b0, 1'b1, 1'b0);
        add(2, 1'b1, 16'd1,  1'b1, 1'b0, 1'b1, 1'b0);

        rst_d = 1'b1; run_d = 1'b0;
        rst_f = 1'b1; run_f = 1'b0;
        rst_s = 1'b1; run_s = 1'b0;
        repeat (2) step();

        check("rst_h", h_d, 0);
        check("rst_hsync", hs_d, 1);
        check("rst_vis", vis_d, 1);
        check("rst_pix", pix_d, 0);
        check("rst_en", en_d, 0);
        run_f = 1'b1;
        #1;
        check("rst_overrides_run_pix", pix_f, 0);

        // ---------------- defaults: two full lines from reset ----------------
        run_d = 1'b1;
        step();
        rst_d = 1'b0;
        #1;
        first_en = -1; second_en = -1; bad = 0; hs_ticks = 0; vis_ticks = 0;
        hs_min = 99999; hs_max = -1; h_max = 0; h_at_en = 16'hffff;
        for (int c = 0; c < 6405; c++) begin
            if (pix_d !== ((c % 4) == 3)) bad++;
            if (int'(h_d) > h_max) h_max = int'(h_d);
            if (en_d === 1'b1) begin
                if (first_en < 0) begin
                    first_en = c;
                    h_at_en = h_d;
                end else if (second_en < 0) begin
                    second_en = c;
                end
            end
            if (c < 3200 && pix_d === 1'b1) begin
                if (hs_d === 1'b0) begin
                    hs_ticks++;
                    if (int'(h_d) < hs_min) hs_min = int'(h_d);
                    if (int'(h_d) > hs_max) hs_max = int'(h_d);
                end
                if (vis_d === 1'b1) vis_ticks++;
            end
            if (c == 3200) check("wrap_to_0", h_d, 0);
            step();
        end
        check("pix_every_4", bad, 0);
        check("first_en_cycle", first_en, 3199);
        check("h_at_en", h_at_en, 799);
        check("second_en_cycle", second_en, 6399);
        check("h_max", h_max, 799);
        check("hsync_ticks", hs_ticks, 96);
        check("hsync_first_col", hs_min, 656);
        check("hsync_last_col", hs_max, 751);
        check("visible_ticks", vis_ticks, 640);

        // ---------------- run dropped at column 799, divider 2 ----------------
        n = 0;
        while (h_d !== 16'd799 && n < 4000) begin step(); n++; end
        check("reach_799", h_d, 799);
        step(); step();
        check("hsync_at_799", hs_d, 1);
        check("vis_at_799", vis_d, 0);
        run_d = 1'b0;
        #1;
        check("drop_pix", pix_d, 0);
        check("drop_en", en_d, 0);
        bad = 0;
        repeat (10) begin
            step();
            if (h_d !== 16'd799 || hs_d !== 1'b1 || vis_d !== 1'b0 || pix_d !== 1'b0 || en_d !== 1'b0)
                bad++;
        end
        check("hold_10_clks", bad, 0);
        run_d = 1'b1;
        #1;
        check("resume_div2_en", en_d, 0);
        step();
        check("resume_pix", pix_d, 1);
        check("resume_en", en_d, 1);
        check("resume_h", h_d, 799);
        step();
        check("resume_wrap_h", h_d, 0);
        check("resume_wrap_en", en_d, 0);
        check("resume_wrap_vis", vis_d, 1);

        // ---------------- reset in the middle of sync ----------------
        n = 0;
        while (h_d !== 16'd700 && n < 4000) begin step(); n++; end
        check("reach_700", h_d, 700);
        check("sync_active_700", hs_d, 0);
        step(); step(); step();
        check("tick_pending_700", pix_d, 1);
        rst_d = 1'b1;
        #1;
        check("rst_kills_tick", pix_d, 0);
        step();
        check("midrst_h", h_d, 0);
        check("midrst_hsync", hs_d, 1);
        check("midrst_vis", vis_d, 1);
        check("midrst_en", en_d, 0);
        rst_d = 1'b0;
        #1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (pix_d !== (c == 3)) bad++;
            step();
        end
        check("first_tick_after_rst", bad, 0);

        // ---------------- CLK_DIV = 1 ----------------
        step();
        rst_f = 1'b0;
        #1;
        bad = 0; first_en = -1; second_en = -1;
        for (int c = 0; c < 1605; c++) begin
            if (pix_f !== 1'b1) bad++;
            if (en_f === 1'b1) begin
                if (first_en < 0) first_en = c;
                else if (second_en < 0) second_en = c;
            end
            step();
        end
        check("div1_pix_const", bad, 0);
        check("div1_first_en", first_en, 799);
        check("div1_en_period", second_en - first_en, 800);
        n = 0;
        while (h_f !== 16'd799 && n < 1000) begin step(); n++; end
        check("div1_en_at_799", en_f, 1);
        rst_f = 1'b1;
        #1;
        check("div1_rst_blocks_en", en_f, 0);
        step();
        check("div1_rst_h", h_f, 0);
        rst_f = 1'b0;
        run_f = 1'b0;
        #1;
        check("div1_pix_run0", pix_f, 0);
        run_f = 1'b1;
        #1;
        check("div1_pix_run1", pix_f, 1);

        // ---------------- small line vector table ----------------
        run_s = 1'b1;
        step();
        rst_s = 1'b0;
        foreach (vecs[i]) begin
            run_s = vecs[i].run;
            repeat (vecs[i].clks) step();
            #1;
            check($sformatf("vec%0d_h", i),    h_s,   vecs[i].h);
            check($sformatf("vec%0d_tick", i), pix_s, vecs[i].tick);
            check($sformatf("vec%0d_hs", i),   hs_s,  vecs[i].hs);
            check($sformatf("vec%0d_vis", i),  vis_s, vecs[i].vis);
            check($sformatf("vec%0d_en", i),   en_s,  vecs[i].en);
        end
        n = 0;
        while (en_s !== 1'b1 && n < 100) begin step(); n++; end
        check("small_next_en", n, 24);
        n = 0;
        step();
        while (en_s !== 1'b1 && n < 100) begin step(); n++; end
        check("small_en_period", n + 1, 28);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
